// File: rtl/tap_reg_shifter_pkg.sv
// rtl/tap_reg_shifter_pkg.sv - shared TAP state codes, instruction codes and helpers
//
// Purpose: TAP controller state encoding (shared with TAP_route), instruction
//          codes understood by tap_reg_shifter, and the is_shift() helper.
// Ports:   none (package).
package tap_pkg;

  // Fixed 4-bit state encoding driven by the TAP controller.
  typedef enum logic [3:0] {
    ST_EX2_DR   = 4'h0,
    ST_EX1_DR   = 4'h1,
    ST_SH_DR    = 4'h2,
    ST_PAUSE_DR = 4'h3,
    ST_SEL_IR   = 4'h4,
    ST_UPD_DR   = 4'h5,
    ST_CAP_DR   = 4'h6,
    ST_SEL_DR   = 4'h7,
    ST_EX2_IR   = 4'h8,
    ST_EX1_IR   = 4'h9,
    ST_SH_IR    = 4'hA,
    ST_PAUSE_IR = 4'hB,
    ST_RTI      = 4'hC,
    ST_UPD_IR   = 4'hD,
    ST_CAP_IR   = 4'hE,
    ST_TLR      = 4'hF
  } tap_state_e;

  // Instruction codes; BYPASS is all ones at whatever IR width is used.
  localparam int unsigned INSTR_CODE_IDCODE = 1;
  localparam int unsigned INSTR_CODE_USER   = 2;

  // Data register selected by the current instruction.
  typedef enum logic [1:0] {
    SEL_BYPASS = 2'd0,
    SEL_IDCODE = 2'd1,
    SEL_USER   = 2'd2
  } dr_sel_e;

  function automatic logic is_shift(input tap_state_e state);
    return (state == ST_SH_IR) || (state == ST_SH_DR);
  endfunction

endpackage

// File: rtl/tap_reg_shifter_if.sv
// rtl/tap_reg_shifter_if.sv - TAP serial bus between controller side and register stage
//
// Purpose: groups the controller state code, serial in and serial out signals.
// Signals: tap_state (state code for the current cycle), tdi (serial in),
//          tdo (serial out), tdo_en (serial out valid, Shift-IR/Shift-DR only).
// Modports: master = controller/test side, slave = tap_reg_shifter.
interface tap_reg_shifter_if;
  import tap_pkg::*;

  tap_state_e tap_state;
  logic       tdi;
  logic       tdo;
  logic       tdo_en;

  modport master (output tap_state, output tdi, input tdo, input tdo_en);
  modport slave  (input tap_state, input tdi, output tdo, output tdo_en);

endinterface

// File: rtl/tap_reg_shifter_shift_reg.sv
// rtl/tap_reg_shifter_shift_reg.sv - capture/shift/hold register used for IR, IDCODE and USER
//
// Purpose: W-bit register; capture_en loads capture_val, shift_en shifts right
//          with tdi entering at the MSB, otherwise holds. Capture wins over shift.
// Ports:   clk, rst_n (async active-low, clears to 0), capture_en, capture_val[W],
//          shift_en, tdi, q[W].
module tap_shift_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         capture_en,
  input  logic [W-1:0] capture_val,
  input  logic         shift_en,
  input  logic         tdi,
  output logic [W-1:0] q
);

  logic [W-1:0] shifted;

  // Written as shift-then-overwrite-MSB so W=1 degenerates to q <= tdi.
  always_comb begin
    shifted      = q >> 1;
    shifted[W-1] = tdi;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (capture_en) begin
      q <= capture_val;
    end else if (shift_en) begin
      q <= shifted;
    end
  end

endmodule

// File: rtl/tap_reg_shifter.sv
// rtl/tap_reg_shifter.sv - JTAG IR/BYPASS/IDCODE/USER register stage behind the TAP controller
//
// Purpose: instruction register plus BYPASS, IDCODE and USER data registers,
//          stepped by the controller state code each GCLK cycle; drives TDO.
// Option:  TAP_IDCODE_EN - when defined, the IDCODE register exists and is the
//          reset instruction; when undefined, code 1 decodes as BYPASS and the
//          reset instruction is all ones.
// Ports:   GCLK, TRST_N (async active-low), tap (slave: tap_state, tdi, tdo, tdo_en),
//          user_capture[DR_W] (captured in Capture-DR), ir_q[IR_W] (current
//          instruction), user_q[DR_W] (USER update register), user_upd (1-cycle
//          strobe when user_q is written).
module tap_reg_shifter
  import tap_pkg::*;
#(
  parameter int IR_W = 4,
  parameter int DR_W = 8
`ifdef TAP_IDCODE_EN
  ,
  parameter logic [31:0] IDCODE_VAL = 32'h1000_563D
`endif
) (
  input  logic                GCLK,
  input  logic                TRST_N,
  tap_reg_shifter_if.slave    tap,
  input  logic [DR_W-1:0]     user_capture,
  output logic [IR_W-1:0]     ir_q,
  output logic [DR_W-1:0]     user_q,
  output logic                user_upd
);

  localparam logic [IR_W-1:0] IR_CAPTURE  = {{(IR_W-1){1'b0}}, 1'b1};
  localparam logic [IR_W-1:0] CODE_IDCODE = IR_W'(INSTR_CODE_IDCODE);
  localparam logic [IR_W-1:0] CODE_USER   = IR_W'(INSTR_CODE_USER);
`ifdef TAP_IDCODE_EN
  localparam logic [IR_W-1:0] IR_RESET    = CODE_IDCODE;
  localparam dr_sel_e         IDCODE_SEL  = SEL_IDCODE;
`else
  localparam logic [IR_W-1:0] IR_RESET    = '1;
  localparam dr_sel_e         IDCODE_SEL  = SEL_BYPASS;
`endif

  tap_state_e      state;
  dr_sel_e         dr_sel;
  logic [IR_W-1:0] ir_sr;
  logic [DR_W-1:0] dr_sr;
  logic            bypass;
  logic            tdo_int;
  logic            cap_dr;
  logic            sh_dr;

  assign state  = tap.tap_state;
  assign cap_dr = (state == ST_CAP_DR);
  assign sh_dr  = (state == ST_SH_DR);

  // ir_q only moves in Update-IR/TLR, so this selection is stable over a DR scan.
  always_comb begin
    dr_sel = SEL_BYPASS;
    if (ir_q == CODE_USER) begin
      dr_sel = SEL_USER;
    end else if (ir_q == CODE_IDCODE) begin
      dr_sel = IDCODE_SEL;
    end
  end

  tap_shift_reg #(.W(IR_W)) u_ir_sr (
    .clk         (GCLK),
    .rst_n       (TRST_N),
    .capture_en  (state == ST_CAP_IR),
    .capture_val (IR_CAPTURE),
    .shift_en    (state == ST_SH_IR),
    .tdi         (tap.tdi),
    .q           (ir_sr)
  );

  tap_shift_reg #(.W(DR_W)) u_user_sr (
    .clk         (GCLK),
    .rst_n       (TRST_N),
    .capture_en  (cap_dr && (dr_sel == SEL_USER)),
    .capture_val (user_capture),
    .shift_en    (sh_dr && (dr_sel == SEL_USER)),
    .tdi         (tap.tdi),
    .q           (dr_sr)
  );

`ifdef TAP_IDCODE_EN
  logic [31:0] id_sr;

  tap_shift_reg #(.W(32)) u_id_sr (
    .clk         (GCLK),
    .rst_n       (TRST_N),
    .capture_en  (cap_dr && (dr_sel == SEL_IDCODE)),
    .capture_val (IDCODE_VAL),
    .shift_en    (sh_dr && (dr_sel == SEL_IDCODE)),
    .tdi         (tap.tdi),
    .q           (id_sr)
  );
`endif

  always_ff @(posedge GCLK or negedge TRST_N) begin
    if (!TRST_N) begin
      ir_q     <= IR_RESET;
      bypass   <= 1'b0;
      user_q   <= '0;
      user_upd <= 1'b0;
    end else begin
      // Strobe is high exactly for the cycle following Update-DR under USER.
      user_upd <= (state == ST_UPD_DR) && (dr_sel == SEL_USER);

      if (state == ST_TLR) begin
        ir_q <= IR_RESET;
      end else if (state == ST_UPD_IR) begin
        ir_q <= ir_sr;
      end

      if ((state == ST_UPD_DR) && (dr_sel == SEL_USER)) begin
        user_q <= dr_sr;
      end

      if (cap_dr && (dr_sel == SEL_BYPASS)) begin
        bypass <= 1'b0;
      end else if (sh_dr && (dr_sel == SEL_BYPASS)) begin
        bypass <= tap.tdi;
      end
    end
  end

  always_comb begin
    tdo_int = 1'b0;
    if (state == ST_SH_IR) begin
      tdo_int = ir_sr[0];
    end else if (sh_dr) begin
      case (dr_sel)
        SEL_USER:   tdo_int = dr_sr[0];
`ifdef TAP_IDCODE_EN
        SEL_IDCODE: tdo_int = id_sr[0];
`endif
        default:    tdo_int = bypass;
      endcase
    end
  end

  assign tap.tdo    = tdo_int;
  assign tap.tdo_en = is_shift(state);

endmodule

// File: tb/tb_tap_reg_shifter.sv
// tb/tb_tap_reg_shifter.sv - directed self-checking bench for tap_reg_shifter
module tb_tap_reg_shifter;
  import tap_pkg::*;

`ifdef TAP_IDCODE_EN
  localparam logic [3:0]  IR_RST  = 4'h1;
  localparam logic [31:0] ID_EXP  = 32'h1000_563D;
`else
  localparam logic [3:0]  IR_RST  = 4'hF;
  // BYPASS: first bit is the captured 0, then tdi delayed one cycle.
  localparam logic [31:0] ID_EXP  = 32'hBD5B_7DDE;
`endif

  logic       gclk;
  logic       trst_n;
  logic [7:0] user_capture;
  logic [3:0] ir_q;
  logic [7:0] user_q;
  logic       user_upd;

  int n_tests;
  int n_fail;

  tap_reg_shifter_if tap_bus ();

  tap_reg_shifter #(.IR_W(4), .DR_W(8)) dut (
    .GCLK         (gclk),
    .TRST_N       (trst_n),
    .tap          (tap_bus.slave),
    .user_capture (user_capture),
    .ir_q         (ir_q),
    .user_q       (user_q),
    .user_upd     (user_upd)
  );

  initial gclk = 1'b0;
  always #5 gclk = ~gclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Present one controller state for one cycle; outputs are valid on return.
  task automatic step(input tap_state_e st, input logic t);
    @(negedge gclk);
    tap_bus.tap_state = st;
    tap_bus.tdi       = t;
    #1;
  endtask

  task automatic load_ir(input logic [3:0] code);
    logic [3:0] got;
    step(ST_SEL_DR, 1'b0);
    step(ST_SEL_IR, 1'b0);
    step(ST_CAP_IR, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(ST_SH_IR, code[i]);
      got[i] = tap_bus.tdo;
    end
    step(ST_EX1_IR, 1'b0);
    step(ST_UPD_IR, 1'b0);
    step(ST_RTI, 1'b0);
    check("ir_capture_tdo", {28'd0, got}, 32'h1);
    check("ir_q_loaded", {28'd0, ir_q}, {28'd0, code});
  endtask

  initial begin
    logic [31:0] pat32;
    logic [31:0] got32;
    logic [7:0]  pat;
    logic [7:0]  got;
    logic [3:0]  bp_in;
    logic [3:0]  bp_exp;
    int          en_cnt;

    n_tests = 0;
    n_fail  = 0;
    trst_n  = 1'b0;
    tap_bus.tap_state = ST_TLR;
    tap_bus.tdi       = 1'b0;
    user_capture      = 8'h00;
    #23;
    check("rst_ir_q", {28'd0, ir_q}, {28'd0, IR_RST});
    check("rst_user_q", {24'd0, user_q}, 32'h0);
    check("rst_user_upd", {31'd0, user_upd}, 32'h0);
    check("rst_tdo", {31'd0, tap_bus.tdo}, 32'h0);
    check("rst_tdo_en", {31'd0, tap_bus.tdo_en}, 32'h0);
    @(negedge gclk);
    trst_n = 1'b1;

    // IDCODE scan straight out of reset.
    pat32  = 32'hDEAD_BEEF;
    en_cnt = 0;
    step(ST_TLR, 1'b0);
    step(ST_RTI, 1'b0);
    step(ST_SEL_DR, 1'b0);
    step(ST_CAP_DR, 1'b0);
    for (int i = 0; i < 32; i++) begin
      step(ST_SH_DR, pat32[i]);
      got32[i] = tap_bus.tdo;
      en_cnt += int'(tap_bus.tdo_en);
    end
    step(ST_EX1_DR, 1'b0);
    check("id_tdo_en_off", {31'd0, tap_bus.tdo_en}, 32'h0);
    step(ST_UPD_DR, 1'b0);
    step(ST_RTI, 1'b0);
    check("id_scan", got32, ID_EXP);
    check("id_tdo_en_cnt", en_cnt, 32);
    check("id_no_upd", {31'd0, user_upd}, 32'h0);

    // Select USER, then abort a DR scan with TRST_N.
    load_ir(4'h2);
    user_capture = 8'h77;
    step(ST_SEL_DR, 1'b0);
    step(ST_CAP_DR, 1'b0);
    for (int i = 0; i < 3; i++) step(ST_SH_DR, 1'b1);
    #2;
    trst_n = 1'b0;
    #1;
    check("abort_ir_q", {28'd0, ir_q}, {28'd0, IR_RST});
    check("abort_user_q", {24'd0, user_q}, 32'h0);
    check("abort_tdo", {31'd0, tap_bus.tdo}, 32'h0);
    step(ST_UPD_DR, 1'b0);
    step(ST_RTI, 1'b0);
    check("abort_no_upd", {31'd0, user_upd}, 32'h0);
    check("abort_user_q_held", {24'd0, user_q}, 32'h0);
    @(negedge gclk);
    trst_n = 1'b1;
    step(ST_TLR, 1'b0);
    step(ST_RTI, 1'b0);

    // USER round trip.
    load_ir(4'h2);
    user_capture = 8'hA5;
    pat = 8'h3C;
    step(ST_SEL_DR, 1'b0);
    step(ST_CAP_DR, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(ST_SH_DR, pat[i]);
      got[i] = tap_bus.tdo;
    end
    step(ST_EX1_DR, 1'b0);
    step(ST_UPD_DR, 1'b0);
    check("user_upd_before", {31'd0, user_upd}, 32'h0);
    step(ST_RTI, 1'b0);
    check("user_q_rt", {24'd0, user_q}, 32'h3C);
    check("user_upd_pulse", {31'd0, user_upd}, 32'h1);
    step(ST_RTI, 1'b0);
    check("user_upd_one_cycle", {31'd0, user_upd}, 32'h0);
    check("user_tdo_rt", {24'd0, got}, 32'hA5);

    // Pause in the middle of a USER scan and resume.
    user_capture = 8'h5A;
    pat = 8'hB6;
    step(ST_SEL_DR, 1'b0);
    step(ST_CAP_DR, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(ST_SH_DR, pat[i]);
      got[i] = tap_bus.tdo;
    end
    step(ST_EX1_DR, 1'b1);
    for (int i = 0; i < 5; i++) step(ST_PAUSE_DR, 1'b1);
    check("pause_tdo_en", {31'd0, tap_bus.tdo_en}, 32'h0);
    step(ST_EX2_DR, 1'b1);
    for (int i = 3; i < 8; i++) begin
      step(ST_SH_DR, pat[i]);
      got[i] = tap_bus.tdo;
    end
    step(ST_EX1_DR, 1'b0);
    step(ST_UPD_DR, 1'b0);
    step(ST_RTI, 1'b0);
    check("pause_user_q", {24'd0, user_q}, 32'hB6);
    check("pause_tdo", {24'd0, got}, 32'h5A);

    // BYPASS: one-cycle tdi to tdo delay after a captured 0.
    load_ir(4'hF);
    bp_in  = 4'b1101;
    bp_exp = 4'b1010;
    step(ST_SEL_DR, 1'b0);
    step(ST_CAP_DR, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(ST_SH_DR, bp_in[i]);
      check($sformatf("bypass_tdo%0d", i), {31'd0, tap_bus.tdo}, {31'd0, bp_exp[i]});
    end
    step(ST_EX1_DR, 1'b0);
    step(ST_UPD_DR, 1'b0);
    step(ST_RTI, 1'b0);
    check("bypass_no_upd", {31'd0, user_upd}, 32'h0);
    check("bypass_user_q_held", {24'd0, user_q}, 32'hB6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
